disp_demux: RTL
===============

Name: disp_demux

Overview:
Receive side of the 4-digit multiplexed seven-segment interface: observes the active-low anode strobes and segment bus and rebuilds the four static 8-bit digit patterns that were time-multiplexed onto it. Also decodes each pattern back to a hex nibble, flags malformed scans and reports frame completion and scan stalls. Used as an on-chip loopback monitor and as the bench-side checker for the display datapath; it sits on the same clock as the display driver.

Parameters:
STABLE_CYCLES, 4, consecutive identical samples of {an,sseg} required before a digit is captured (min 2)
TIMEOUT_CYCLES, 1048576, cycles without any capture before stalled asserts (min 2)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
an  in  4  anode strobes, active-low, expected one-hot-low or 4'b1111 (blank)
sseg  in  8  segment bus, active-low, bit0=a ... bit6=g, bit7=dp
out0..out3  out  8 each  reconstructed active-low pattern for digit 0..3 (digit k strobed by an[k]=0)
hex  out  16  decoded nibbles, hex[4k+3:4k] = digit k
hex_ok  out  4  hex_ok[k]=1 when out_k[6:0] matches a hex glyph
frame_done  out  1  one-cycle pulse when all four digits have been captured since the last pulse
scan_err  out  1  sticky: an was seen with more than one low bit
stalled  out  1  no capture for TIMEOUT_CYCLES cycles

Behaviour:
- Reset (synchronous, active-high, takes priority over everything): out0..3=8'hFF, hex=0, hex_ok=0, frame_done=0, scan_err=0, stalled=0; seen mask, stability counter and timeout counter=0; sample register loaded with {4'hF,8'hFF}.
- Sampling: {an,sseg} registered every cycle into samp; the previous samp is kept as prev.
- Stability: if samp==prev, stab_cnt increments, saturating at STABLE_CYCLES-1; otherwise stab_cnt=0.
- Capture: fires exactly once per dwell, on the cycle stab_cnt goes from STABLE_CYCLES-2 to STABLE_CYCLES-1, and only when samp.an has exactly one low bit k. That cycle out_k<=samp.sseg and seen[k]<=1. Timing: if the pins are constant from the first sampling edge E, out_k updates at edge E+STABLE_CYCLES-1. Dwells shorter than STABLE_CYCLES samples are discarded.
- Blank (an=4'b1111): no capture, no error.
- Multi-low an (two or more bits 0), once stable for the same STABLE_CYCLES: no capture, scan_err<=1. scan_err stays set until reset.
- Frame: when a capture makes seen==4'b1111, frame_done=1 for that one cycle and seen<=0 on the same edge. Re-capturing an already-seen digit does not pulse.
- Decode: registered, one cycle after out_k changes. Active-low {g..a} table:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
  - dp is ignored.
  - No match: hex nibble=0, hex_ok[k]=0.
- Timeout: to_cnt clears on every capture and otherwise increments, saturating. stalled=1 while to_cnt>=TIMEOUT_CYCLES; it drops on the edge of the next capture.
- Reset mid-frame: partial seen mask is discarded and no frame_done is emitted for that frame.

Test Plan:
- Reset, then scan an=1110/1101/1011/0111 with sseg=C0/F9/A4/B0, each held 8 cycles (STABLE_CYCLES=4) -> out0..3=C0,F9,A4,B0; hex=16'h3210; hex_ok=4'hF; exactly one frame_done pulse, on the digit-3 capture edge.
- an=1101, sseg=92 held 3 cycles, then an=1111 -> out1 stays FF, no seen bit set, no frame_done.
- an=1100 held 10 cycles -> scan_err=1, no out change. Next, valid scans -> captures still occur; scan_err stays 1 until reset.
- Rotating-square pattern an=1110, sseg=9C held 8 cycles -> out0=9C, hex_ok[0]=0, hex[3:0]=0.
- TIMEOUT_CYCLES=64: one capture, then an=1111 for 70 cycles -> stalled rises 64 cycles after the capture edge. A subsequent valid dwell -> stalled=0 on its capture edge.
- Capture digits 0 and 1, assert reset for 1 cycle, then capture digits 2 and 3 -> all outputs at reset values after the reset edge; no frame_done until digits 0 and 1 are captured again.

Source files
------------

// File: rtl/disp_demux.sv
// Receive side of the 4-digit multiplexed seven-segment bus: rebuilds the four
// static digit patterns from the strobed anode/segment lines and decodes them.
module disp_demux #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  an,
    input  logic [7:0]  sseg,
    output logic [7:0]  out0,
    output logic [7:0]  out1,
    output logic [7:0]  out2,
    output logic [7:0]  out3,
    output logic [15:0] hex,
    output logic [3:0]  hex_ok,
    output logic        frame_done,
    output logic        scan_err,
    output logic        stalled
);

    localparam int SW = $clog2(STABLE_CYCLES);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] STAB_ARM = SW'(STABLE_CYCLES - 2);
    localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES - 1);
    localparam logic [SW-1:0] STAB_ONE = SW'(1);
    localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TO_ONE   = TW'(1);

    logic [11:0]   samp;
    logic [SW-1:0] stab_cnt;
    logic [TW-1:0] to_cnt;
    logic [TW-1:0] to_nxt;
    logic [3:0]    seen;
    logic [3:0]    seen_upd;
    logic [7:0]    dig [4];
    logic [3:0]    an_low;
    logic [1:0]    cap_idx;
    logic          one_low;
    logic          multi_low;
    logic          same;
    logic          dwell_done;
    logic          capture;

    assign out0 = dig[0];
    assign out1 = dig[1];
    assign out2 = dig[2];
    assign out3 = dig[3];

    // Compare the incoming pins with the last sample so a dwell that starts at
    // edge E is accepted at edge E+STABLE_CYCLES-1.
    assign same       = ({an, sseg} == samp);
    assign dwell_done = same && (stab_cnt == STAB_ARM);
    assign an_low     = ~samp[11:8];
    assign multi_low  = (an_low & (an_low - 4'd1)) != 4'd0;
    assign capture    = dwell_done && one_low;
    assign seen_upd   = seen | (4'b0001 << cap_idx);
    assign to_nxt     = capture ? '0 : ((to_cnt == TO_MAX) ? to_cnt : to_cnt + TO_ONE);

    always_comb begin
        cap_idx = 2'd0;
        one_low = 1'b1;
        case (samp[11:8])
            4'b1110: cap_idx = 2'd0;
            4'b1101: cap_idx = 2'd1;
            4'b1011: cap_idx = 2'd2;
            4'b0111: cap_idx = 2'd3;
            default: one_low = 1'b0;
        endcase
    end

    // Returns {valid, nibble} for an active-low {g..a} glyph.
    function automatic logic [4:0] decode(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'h40:   r = {1'b1, 4'h0};
            7'h79:   r = {1'b1, 4'h1};
            7'h24:   r = {1'b1, 4'h2};
            7'h30:   r = {1'b1, 4'h3};
            7'h19:   r = {1'b1, 4'h4};
            7'h12:   r = {1'b1, 4'h5};
            7'h02:   r = {1'b1, 4'h6};
            7'h78:   r = {1'b1, 4'h7};
            7'h00:   r = {1'b1, 4'h8};
            7'h10:   r = {1'b1, 4'h9};
            7'h08:   r = {1'b1, 4'hA};
            7'h03:   r = {1'b1, 4'hB};
            7'h46:   r = {1'b1, 4'hC};
            7'h21:   r = {1'b1, 4'hD};
            7'h06:   r = {1'b1, 4'hE};
            7'h0E:   r = {1'b1, 4'hF};
            default: r = 5'd0;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            samp       <= 12'hFFF;
            stab_cnt   <= '0;
            to_cnt     <= '0;
            seen       <= 4'd0;
            frame_done <= 1'b0;
            scan_err   <= 1'b0;
            stalled    <= 1'b0;
            hex        <= 16'd0;
            hex_ok     <= 4'd0;
            for (int k = 0; k < 4; k++) dig[k] <= 8'hFF;
        end else begin
            samp       <= {an, sseg};
            frame_done <= 1'b0;
            to_cnt     <= to_nxt;
            stalled    <= (to_nxt >= TO_MAX);

            if (!same)
                stab_cnt <= '0;
            else if (stab_cnt != STAB_MAX)
                stab_cnt <= stab_cnt + STAB_ONE;

            if (capture) begin
                dig[cap_idx] <= samp[7:0];
                if (seen_upd == 4'b1111) begin
                    seen       <= 4'd0;
                    frame_done <= 1'b1;
                end else begin
                    seen <= seen_upd;
                end
            end

            if (dwell_done && multi_low)
                scan_err <= 1'b1;

            for (int k = 0; k < 4; k++)
                {hex_ok[k], hex[4*k +: 4]} <= decode(dig[k][6:0]);
        end
    end

endmodule
